// File: rtl/coo_spmm_accumulator.sv
// coo_spmm_accumulator: streams 1-based COO edges against one dense
// feature-weight row at a time. It accumulates the products into a
// NUM_NODES x FEAT_COLS register array, then drains that array row by row
// over a valid/ready port.
module coo_spmm_accumulator #(
  parameter int NUM_NODES = 6,
  parameter int FEAT_COLS = 3,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = $clog2(NUM_NODES + 1),
  parameter int ROW_W     = $clog2(NUM_NODES),
  parameter int SYMMETRIC = 1,
  parameter int SATURATE  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          row_valid,
  output logic                          row_ready,
  input  logic [ROW_W-1:0]              row_idx,
  input  logic                          row_last,
  input  logic [FEAT_COLS*DATA_W-1:0]   row_data,
  input  logic                          edge_valid,
  output logic                          edge_ready,
  input  logic [IDX_W-1:0]              edge_src,
  input  logic [IDX_W-1:0]              edge_dst,
  input  logic                          edge_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROW_W-1:0]              out_row,
  output logic [FEAT_COLS*DATA_W-1:0]   out_data,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   bad_edge_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ROW, S_EDGES, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   acc   [NUM_NODES][FEAT_COLS];
  logic [DATA_W-1:0]   row_q [FEAT_COLS];
  logic [ROW_W-1:0]    k_q;
  logic                row_last_q;
  logic [ROW_W-1:0]    out_row_q;
  logic                done_q;
  logic [15:0]         bad_cnt_q;

  logic                start_ok, row_fire, edge_fire, out_fire, drain_last;
  logic                idx_ok, hit;
  logic [IDX_W-1:0]    a_idx, b_idx, k_ext, tgt;
  logic [ROW_W-1:0]    tgt_row;

  // Signed add with a one-bit-wider sum. The result either clamps or wraps.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {x[DATA_W-1], x} + {y[DATA_W-1], y};
    if (SATURATE != 0 && s[DATA_W] != s[DATA_W-1])
      sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = s[DATA_W-1:0];
  endfunction

  assign start_ok   = start && (state == S_IDLE);
  assign row_fire   = row_valid && row_ready;
  assign edge_fire  = edge_valid && edge_ready;
  assign out_fire   = out_valid && out_ready;
  assign drain_last = out_fire && (out_row_q == ROW_W'(NUM_NODES - 1));

  assign row_ready    = (state == S_WAIT_ROW);
  assign edge_ready   = (state == S_EDGES);
  assign out_valid    = (state == S_DRAIN);
  assign busy         = (state != S_IDLE);
  assign done         = done_q;
  assign out_row      = out_row_q;
  assign bad_edge_cnt = bad_cnt_q;

  // Decode the edge: range check, convert to 0-based indices, pick the target row.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path leaves it unassigned (no latch).
    hit     = 1'b0;
    tgt     = '0;
    k_ext   = IDX_W'(k_q);
    a_idx   = edge_src - IDX_W'(1);
    b_idx   = edge_dst - IDX_W'(1);
    idx_ok  = (edge_src != '0) && (edge_src <= IDX_W'(NUM_NODES)) &&
              (edge_dst != '0) && (edge_dst <= IDX_W'(NUM_NODES));
    if (idx_ok) begin
      if (b_idx == k_ext) begin
        hit = 1'b1;
        tgt = a_idx;
      end else if (SYMMETRIC != 0 && a_idx == k_ext) begin
        hit = 1'b1;
        tgt = b_idx;
      end
    end
    tgt_row = ROW_W'(tgt);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_WAIT_ROW;
      S_WAIT_ROW: if (row_fire) state_nxt = S_EDGES;
      S_EDGES:    if (edge_fire && edge_last) state_nxt = row_last_q ? S_DRAIN : S_WAIT_ROW;
      S_DRAIN:    if (drain_last) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Latch the presented row, its index k and its last flag on the row handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < FEAT_COLS; j++) row_q[j] <= '0;
      k_q        <= '0;
      row_last_q <= 1'b0;
    end else if (row_fire) begin
      for (int j = 0; j < FEAT_COLS; j++) row_q[j] <= row_data[j*DATA_W +: DATA_W];
      k_q        <= row_idx;
      row_last_q <= row_last;
    end
  end

  // Accumulator array: cleared by start, read-modify-write on each hitting edge.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the accumulator array is reset explicitly because its reset contents (all zero) are observable.
    if (reset) begin
      for (int r = 0; r < NUM_NODES; r++)
        for (int j = 0; j < FEAT_COLS; j++) acc[r][j] <= '0;
    end else if (start_ok) begin
      for (int r = 0; r < NUM_NODES; r++)
        for (int j = 0; j < FEAT_COLS; j++) acc[r][j] <= '0;
    end else if (edge_fire && hit) begin
      for (int r = 0; r < NUM_NODES; r++)
        if (ROW_W'(r) == tgt_row)
          for (int j = 0; j < FEAT_COLS; j++) acc[r][j] <= sat_add(acc[r][j], row_q[j]);
    end
  end

  // Drain row pointer and the one-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_row_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= drain_last;
      if (start_ok || drain_last) out_row_q <= '0;
      else if (out_fire)          out_row_q <= out_row_q + ROW_W'(1);
    end
  end

  // Saturating count of dropped out-of-range edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         bad_cnt_q <= '0;
    else if (start_ok)                                 bad_cnt_q <= '0;
    else if (edge_fire && !idx_ok && bad_cnt_q != '1)  bad_cnt_q <= bad_cnt_q + 16'd1;
  end

  // Present the selected accumulator row. It is stable in DRAIN because nothing writes acc there.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < FEAT_COLS; j++) out_data[j*DATA_W +: DATA_W] = acc[out_row_q][j];
  end

endmodule

// File: tb/tb_coo_spmm_accumulator.sv
// Bench for coo_spmm_accumulator. Three instances share one stimulus:
// symmetric/wrap, directed/wrap and symmetric/saturate.
// A reference model in the bench produces the expected accumulator rows,
// which are queued and compared as the DUTs drain.
module tb_coo_spmm_accumulator;
  localparam int NN = 6;
  localparam int FC = 3;
  localparam int DW = 16;
  localparam int IW = 3;
  localparam int RW = 3;

  logic clk = 1'b0;
  logic reset, start;
  logic row_valid, row_last, edge_valid, edge_last, out_ready;
  logic [RW-1:0]    row_idx;
  logic [FC*DW-1:0] row_data;
  logic [IW-1:0]    edge_src, edge_dst;

  logic             row_ready_v [3];
  logic             edge_ready_v[3];
  logic             out_valid_v [3];
  logic             busy_v      [3];
  logic             done_v      [3];
  logic [RW-1:0]    out_row_v   [3];
  logic [FC*DW-1:0] out_data_v  [3];
  logic [15:0]      bad_v       [3];

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int             inst;
    int             row;
    logic [FC*DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic signed [DW-1:0] m_acc [3][NN][FC];
  logic signed [DW-1:0] m_row [FC];
  int m_k, m_bad;
  bit m_last;

  always #5 clk = ~clk;

  coo_spmm_accumulator #(.SYMMETRIC(1), .SATURATE(0)) u_sym (
    .clk(clk), .reset(reset), .start(start),
    .row_valid(row_valid), .row_ready(row_ready_v[0]), .row_idx(row_idx),
    .row_last(row_last), .row_data(row_data),
    .edge_valid(edge_valid), .edge_ready(edge_ready_v[0]), .edge_src(edge_src),
    .edge_dst(edge_dst), .edge_last(edge_last),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_row(out_row_v[0]),
    .out_data(out_data_v[0]), .busy(busy_v[0]), .done(done_v[0]), .bad_edge_cnt(bad_v[0]));

  coo_spmm_accumulator #(.SYMMETRIC(0), .SATURATE(0)) u_dir (
    .clk(clk), .reset(reset), .start(start),
    .row_valid(row_valid), .row_ready(row_ready_v[1]), .row_idx(row_idx),
    .row_last(row_last), .row_data(row_data),
    .edge_valid(edge_valid), .edge_ready(edge_ready_v[1]), .edge_src(edge_src),
    .edge_dst(edge_dst), .edge_last(edge_last),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_row(out_row_v[1]),
    .out_data(out_data_v[1]), .busy(busy_v[1]), .done(done_v[1]), .bad_edge_cnt(bad_v[1]));

  coo_spmm_accumulator #(.SYMMETRIC(1), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .start(start),
    .row_valid(row_valid), .row_ready(row_ready_v[2]), .row_idx(row_idx),
    .row_last(row_last), .row_data(row_data),
    .edge_valid(edge_valid), .edge_ready(edge_ready_v[2]), .edge_src(edge_src),
    .edge_dst(edge_dst), .edge_last(edge_last),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_row(out_row_v[2]),
    .out_data(out_data_v[2]), .busy(busy_v[2]), .done(done_v[2]), .bad_edge_cnt(bad_v[2]));

  function automatic bit cfg_sym(input int c); return c != 1; endfunction
  function automatic bit cfg_sat(input int c); return c == 2; endfunction

  function automatic logic [FC*DW-1:0] mk_row(input int x0, input int x1, input int x2);
    return {16'(x2), 16'(x1), 16'(x0)};
  endfunction

  function automatic logic [FC*DW-1:0] pack(input int c, input int r);
    logic [FC*DW-1:0] p;
    for (int j = 0; j < FC; j++) p[j*DW +: DW] = m_acc[c][r][j];
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < NN; r++)
        for (int j = 0; j < FC; j++) m_acc[c][r][j] = '0;
    m_bad = 0;
  endtask

  task automatic model_edge(input int src, input int dst);
    int a, b, tgt, s;
    if (src < 1 || src > NN || dst < 1 || dst > NN) begin
      if (m_bad < 65535) m_bad++;
      return;
    end
    a = src - 1;
    b = dst - 1;
    for (int c = 0; c < 3; c++) begin
      tgt = -1;
      if (b == m_k) tgt = a;
      else if (cfg_sym(c) && a == m_k) tgt = b;
      if (tgt >= 0)
        for (int j = 0; j < FC; j++) begin
          s = int'(m_acc[c][tgt][j]) + int'(m_row[j]);
          if (cfg_sat(c)) begin
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
          end
          m_acc[c][tgt][j] = 16'(s);
        end
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int c = 0; c < 3; c++) begin
      check({tag, "_busy"},       busy_v[c],       0);
      check({tag, "_row_ready"},  row_ready_v[c],  0);
      check({tag, "_edge_ready"}, edge_ready_v[c], 0);
      check({tag, "_out_valid"},  out_valid_v[c],  0);
      check({tag, "_done"},       done_v[c],       0);
      check({tag, "_out_row"},    out_row_v[c],    0);
      check({tag, "_out_data"},   out_data_v[c],   0);
      check({tag, "_bad_cnt"},    bad_v[c],        0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      check("start_busy",      busy_v[c],      1);
      check("start_row_ready", row_ready_v[c], 1);
      check("start_acc0_zero", out_data_v[c],  0);
      check("start_bad_clear", bad_v[c],       0);
    end
  endtask

  task automatic send_row(input int k, input logic [FC*DW-1:0] d, input bit last);
    int n = 0;
    row_valid = 1'b1;
    row_idx   = RW'(k);
    row_data  = d;
    row_last  = last;
    while (!row_ready_v[0] && n < 20) begin @(posedge clk); #1; n++; end
    if (!row_ready_v[0]) check("row_ready_timeout", 0, 1);
    @(posedge clk); #1;
    row_valid = 1'b0;
    m_k = k;
    m_last = last;
    for (int j = 0; j < FC; j++) m_row[j] = d[j*DW +: DW];
    for (int c = 0; c < 3; c++) check("edge_ready_after_row", edge_ready_v[c], 1);
  endtask

  task automatic send_edge(input int src, input int dst, input bit last, input bit poke_start);
    int n = 0;
    edge_valid = 1'b1;
    edge_src   = IW'(src);
    edge_dst   = IW'(dst);
    edge_last  = last;
    start      = poke_start;
    while (!edge_ready_v[0] && n < 20) begin @(posedge clk); #1; n++; end
    if (!edge_ready_v[0]) check("edge_ready_timeout", 0, 1);
    @(posedge clk); #1;
    edge_valid = 1'b0;
    start      = 1'b0;
    model_edge(src, dst);
    for (int c = 0; c < 3; c++) begin
      check("acc0_after_edge", out_data_v[c], pack(c, 0));
      check("bad_cnt_after_edge", bad_v[c], 64'(m_bad));
      if (last && m_last)  check("out_valid_after_last_edge", out_valid_v[c], 1);
      if (last && !m_last) check("row_ready_after_last_edge", row_ready_v[c], 1);
      if (!last)           check("edge_ready_no_bubble", edge_ready_v[c], 1);
    end
  endtask

  task automatic drain(input int stall_row);
    exp_t e;
    exp_t held[3];
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < 3; c++) exp_q.push_back('{c, r, pack(c, r)});
    out_ready = 1'b1;
    for (int r = 0; r < NN; r++) begin
      int n = 0;
      while (!out_valid_v[0] && n < 20) begin @(posedge clk); #1; n++; end
      if (!out_valid_v[0]) check("out_valid_timeout", 0, 1);
      for (int c = 0; c < 3; c++) begin
        e = exp_q.pop_front();
        held[c] = e;
        check("drain_out_row",  out_row_v[e.inst],  64'(e.row));
        check("drain_out_data", out_data_v[e.inst], e.data);
      end
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          for (int c = 0; c < 3; c++) begin
            check("stall_out_row",   out_row_v[c],   64'(held[c].row));
            check("stall_out_data",  out_data_v[c],  held[c].data);
            check("stall_out_valid", out_valid_v[c], 1);
          end
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      check("done_pulse",      done_v[c], 1);
      check("busy_after_pass", busy_v[c], 0);
      check("bad_cnt_final",   bad_v[c],  64'(m_bad));
    end
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) check("done_one_cycle", done_v[c], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    row_valid = 1'b0; row_idx = '0; row_last = 1'b0; row_data = '0;
    edge_valid = 1'b0; edge_src = '0; edge_dst = '0; edge_last = 1'b0;
    m_k = 0; m_last = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Symmetric basic / directed: one row, two edges, stalled drain.
    do_start();
    send_row(0, mk_row(1, 2, 3), 1'b1);
    send_edge(1, 2, 1'b0, 1'b0);
    send_edge(3, 1, 1'b1, 1'b0);
    drain(1);

    // Multi-row with self-loop, bad edges, and a start pulse ignored mid-pass.
    do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) check("start_ignored_wait_row", row_ready_v[c], 1);
    send_row(0, mk_row(1, 1, 1), 1'b0);
    send_edge(1, 1, 1'b0, 1'b0);
    send_edge(1, 2, 1'b0, 1'b1);
    send_edge(0, 2, 1'b0, 1'b0);
    send_edge(7, 1, 1'b1, 1'b0);
    send_row(1, mk_row(2, 2, 2), 1'b1);
    send_edge(1, 1, 1'b0, 1'b0);
    send_edge(1, 2, 1'b1, 1'b0);
    drain(-1);

    // Saturation versus wrap on three identical edges.
    do_start();
    send_row(0, mk_row(32'h7000, 32'h9000, 1), 1'b1);
    send_edge(1, 2, 1'b0, 1'b0);
    send_edge(1, 2, 1'b0, 1'b0);
    send_edge(1, 2, 1'b1, 1'b0);
    drain(3);

    // Reset in the middle of EDGES, then a fresh pass.
    do_start();
    send_row(0, mk_row(5, 5, 5), 1'b0);
    send_edge(1, 1, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    model_clear();
    check_reset_values("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_start();
    send_row(2, mk_row(4, -1, 7), 1'b1);
    send_edge(3, 3, 1'b0, 1'b0);
    send_edge(2, 3, 1'b1, 1'b0);
    drain(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
